// File: rtl/pwm_light_driver.sv
// PWM light driver: latches a clamped brightness level once per period
// and tracks the level trend, pulsing on each peak and trough.
module pwm_light_driver #(
    parameter int PERIOD      = 10,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] level,
    output logic        pwm_out,
    output logic        period_start,
    output logic [31:0] duty_q,
    output logic        busy,
    output logic        dir_up,
    output logic        peak,
    output logic        trough
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [31:0] PMAX = 32'(PERIOD);
    localparam logic [31:0] LAST = 32'(PERIOD - 1);

    state_t      state, state_nx;
    logic [31:0] phase, phase_nx;
    logic [31:0] duty_nx;
    logic        dir_nx, peak_nx, trough_nx;
    logic [31:0] lvl_c;
    logic        dir_upd;
    logic        on;

    assign lvl_c = (level > PMAX) ? PMAX : level;

    // Flat level keeps the previous trend.
    assign dir_upd = (lvl_c > duty_q) ? 1'b1 :
                     (lvl_c < duty_q) ? 1'b0 : dir_up;

    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        duty_nx   = duty_q;
        dir_nx    = dir_up;
        peak_nx   = 1'b0;
        trough_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nx  = RUN;
                    phase_nx  = '0;
                    duty_nx   = lvl_c;
                    dir_nx    = dir_upd;
                    peak_nx   = dir_up & ~dir_upd;
                    trough_nx = ~dir_up & dir_upd;
                end
            end
            RUN: begin
                if (phase != LAST) begin
                    phase_nx = phase + 32'd1;
                end else if (en) begin
                    phase_nx  = '0;
                    duty_nx   = lvl_c;
                    dir_nx    = dir_upd;
                    peak_nx   = dir_up & ~dir_upd;
                    trough_nx = ~dir_up & dir_upd;
                end else begin
                    state_nx = IDLE;
                    phase_nx = '0;
                    duty_nx  = '0;
                    dir_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= '0;
            duty_q <= '0;
            dir_up <= 1'b1;
            peak   <= 1'b0;
            trough <= 1'b0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            duty_q <= duty_nx;
            dir_up <= dir_nx;
            peak   <= peak_nx;
            trough <= trough_nx;
        end
    end

    assign busy         = (state == RUN);
    assign period_start = busy && (phase == '0);
    assign on           = busy && (phase < duty_q);
    assign pwm_out      = ACTIVE_HIGH ? on : ~on;

endmodule

// File: tb/tb_pwm_light_driver.sv
// Directed bench for pwm_light_driver; a second instance with inverted
// polarity shares the same stimulus.
module tb_pwm_light_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] level = '0;

    logic        pwm, ps, busy, dir, pk, tr;
    logic [31:0] duty;
    logic        pwm_n, ps_n, busy_n, dir_n, pk_n, tr_n;
    logic [31:0] duty_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_light_driver #(.PERIOD(10), .ACTIVE_HIGH(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .level(level),
        .pwm_out(pwm), .period_start(ps), .duty_q(duty),
        .busy(busy), .dir_up(dir), .peak(pk), .trough(tr)
    );

    pwm_light_driver #(.PERIOD(10), .ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .rst(rst), .en(en), .level(level),
        .pwm_out(pwm_n), .period_start(ps_n), .duty_q(duty_n),
        .busy(busy_n), .dir_up(dir_n), .peak(pk_n), .trough(tr_n)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one full period starting at phase 0; optionally changes level
    // after the check at phase chg.
    task automatic run_period(input int d, input bit dexp, input bit pexp,
                              input bit texp, input int chg,
                              input logic [31:0] chg_lvl);
        for (int p = 0; p < 10; p++) begin
            check("pwm", 32'(pwm), 32'(p < d));
            check("pwm_n", 32'(pwm_n), 32'(!(p < d)));
            check("period_start", 32'(ps), 32'(p == 0));
            check("busy", 32'(busy), 32'd1);
            check("duty_q", duty, 32'(d));
            check("dir_up", 32'(dir), 32'(dexp));
            check("peak", 32'(pk), 32'(pexp && p == 0));
            check("trough", 32'(tr), 32'(texp && p == 0));
            if (p == chg) level = chg_lvl;
            tick();
        end
    endtask

    int          seq [14] = '{8, 9, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    bit          sdir[14] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    bit          spk [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit          str [14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        tick();
        tick();
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_pwm_n", 32'(pwm_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_duty", duty, 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_ps", 32'(ps), 32'd0);
        check("rst_peak", 32'(pk), 32'd0);
        check("rst_trough", 32'(tr), 32'd0);

        // Async reset in the middle of a period.
        rst = 1'b0;
        en = 1'b1;
        level = 32'd8;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("mid_pwm", 32'(pwm), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_pwm", 32'(pwm), 32'd0);
        check("arst_pwm_n", 32'(pwm_n), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_duty", duty, 32'd0);
        check("arst_dir", 32'(dir), 32'd1);
        en = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_hold_busy", 32'(busy), 32'd0);
            check("idle_hold_pwm", 32'(pwm), 32'd0);
        end

        // Steady duty 3, mid-period change, clamp, full and zero duty.
        en = 1'b1;
        level = 32'd3;
        tick();
        run_period(3, 1, 0, 0, -1, 0);
        run_period(3, 1, 0, 0, -1, 0);
        run_period(3, 1, 0, 0, 4, 32'd7);
        run_period(7, 1, 0, 0, 0, 32'd25);
        run_period(10, 1, 0, 0, 0, 32'hFFFF_FFFF);
        run_period(10, 1, 0, 0, 0, 32'd0);
        run_period(0, 0, 1, 0, 0, 32'd8);

        // Triangle sweep with peak and trough detection.
        for (int i = 0; i < 14; i++)
            run_period(seq[i], sdir[i], spk[i], str[i], 0,
                       (i < 13) ? 32'(seq[i+1]) : 32'd2);

        // Drop en mid-period: the period still completes.
        for (int p = 0; p < 10; p++) begin
            check("drop_pwm", 32'(pwm), 32'(p < 2));
            check("drop_pwm_n", 32'(pwm_n), 32'(!(p < 2)));
            check("drop_busy", 32'(busy), 32'd1);
            check("drop_duty", duty, 32'd2);
            if (p == 5) en = 1'b0;
            tick();
        end
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_pwm", 32'(pwm), 32'd0);
        check("stop_pwm_n", 32'(pwm_n), 32'd1);
        check("stop_duty", duty, 32'd0);
        check("stop_dir", 32'(dir), 32'd1);
        check("stop_ps", 32'(ps), 32'd0);
        check("stop_peak", 32'(pk), 32'd0);
        check("stop_trough", 32'(tr), 32'd0);
        tick();
        tick();
        check("stop_hold_busy", 32'(busy), 32'd0);
        check("stop_hold_pwm_n", 32'(pwm_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
